// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the RV64I datapath.
// The controller holds the master modport; the datapath side holds the slave modport.
interface multicycle_controller_if #(
    parameter int unsigned XLEN = 64
) ();
    logic [31:0]     Instruction;
    logic            Zero;
    logic            mem_ready;
    logic            mem_req;
    logic            AdrSrc;
    logic            IRWrite;
    logic            PCWrite;
    logic            MemWrite;
    logic            RegWrite;
    logic [1:0]      ALUSrcA;
    logic [1:0]      ALUSrcB;
    logic [1:0]      ResultSrc;
    logic [2:0]      ALUControl;
    logic [XLEN-1:0] Imm;
    logic            instr_done;
    logic            illegal;

    modport master (
        input  Instruction, Zero, mem_ready,
        output mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite,
        output ALUSrcA, ALUSrcB, ResultSrc, ALUControl, Imm, instr_done, illegal
    );

    modport slave (
        output Instruction, Zero, mem_ready,
        input  mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite,
        input  ALUSrcA, ALUSrcB, ResultSrc, ALUControl, Imm, instr_done, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV64I control FSM: sequences fetch/decode/execute/memory/writeback and
// drives datapath selects, enables and the sign-extended immediate.
module multicycle_controller #(
    parameter int unsigned XLEN            = 64,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input logic                     clk,
    input logic                     rst,
    multicycle_controller_if.master ctrl_io
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBeq,
        StJal,
        StTrap
    } state_e;

    state_e state_q, state_d;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    assign instr  = ctrl_io.Instruction;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    logic is_load, is_store, is_reg, is_imm, is_branch, is_jal;

    assign is_load   = (opcode == OpLoad);
    assign is_store  = (opcode == OpStore);
    assign is_reg    = (opcode == OpReg);
    assign is_imm    = (opcode == OpImm);
    assign is_branch = (opcode == OpBranch);
    assign is_jal    = (opcode == OpJal);

    logic mem_f3_ok, alu_f3_ok, reg_funct_ok, instr_legal;

    // Doubleword accesses (funct3 011) exist only on a 64-bit datapath.
    assign mem_f3_ok    = (funct3 == 3'b010) || ((XLEN == 64) && (funct3 == 3'b011));
    assign alu_f3_ok    = (funct3 == 3'b000) || (funct3 == 3'b111) ||
                          (funct3 == 3'b110) || (funct3 == 3'b010);
    assign reg_funct_ok = ((funct7 == 7'b0000000) && alu_f3_ok) ||
                          ((funct7 == 7'b0100000) && (funct3 == 3'b000));
    assign instr_legal  = ((is_load || is_store) && mem_f3_ok) ||
                          (is_reg && reg_funct_ok) ||
                          (is_imm && alu_f3_ok) ||
                          is_branch || is_jal;

    logic [2:0] alu_op;

    always_comb begin
        alu_op = AluAdd;
        case (funct3)
            3'b000:  alu_op = (is_reg && funct7[5]) ? AluSub : AluAdd;
            3'b111:  alu_op = AluAnd;
            3'b110:  alu_op = AluOr;
            3'b010:  alu_op = AluSlt;
            default: alu_op = AluAdd;
        endcase
    end

    logic [XLEN-1:0] imm;

    always_comb begin
        imm = '0;
        case (opcode)
            OpLoad, OpImm: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            OpStore:       imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            OpBranch:      imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                                  instr[30:25], instr[11:8], 1'b0};
            OpJal:         imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                                  instr[20], instr[30:21], 1'b0};
            default:       imm = '0;
        endcase
    end

    logic       mem_req, adr_src, ir_write, pc_update, branch, mem_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] alu_control;
    logic       instr_done, illegal;

    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_update   = 1'b0;
        branch      = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_control = AluAdd;
        instr_done  = 1'b0;
        illegal     = 1'b0;

        unique case (state_q)
            StFetch: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (ctrl_io.mem_ready) begin
                    ir_write  = 1'b1;
                    pc_update = 1'b1;
                    state_d   = StDecode;
                end
            end
            StDecode: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                if (!instr_legal) begin
                    if (TRAP_ON_ILLEGAL) begin
                        state_d = StTrap;
                    end else begin
                        // Illegal word retires as a NOP straight from decode.
                        instr_done = 1'b1;
                        state_d    = StFetch;
                    end
                end else if (is_load || is_store) begin
                    state_d = StMemAdr;
                end else if (is_reg) begin
                    state_d = StExecR;
                end else if (is_imm) begin
                    state_d = StExecI;
                end else if (is_branch) begin
                    state_d = StBeq;
                end else begin
                    state_d = StJal;
                end
            end
            StMemAdr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = is_store ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (ctrl_io.mem_ready) begin
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (ctrl_io.mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end
            end
            StExecR, StExecI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = (state_q == StExecI) ? 2'b01 : 2'b00;
                alu_control = alu_op;
                state_d     = StAluWb;
            end
            StAluWb: begin
                result_src = 2'b00;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StBeq: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b00;
                alu_control = AluSub;
                result_src  = 2'b00;
                branch      = 1'b1;
                instr_done  = 1'b1;
                state_d     = StFetch;
            end
            StJal: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b00;
                pc_update  = 1'b1;
                state_d    = StAluWb;
            end
            StTrap: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    assign ctrl_io.mem_req    = mem_req;
    assign ctrl_io.AdrSrc     = adr_src;
    assign ctrl_io.IRWrite    = ir_write;
    assign ctrl_io.PCWrite    = pc_update | (branch & ctrl_io.Zero);
    assign ctrl_io.MemWrite   = mem_write;
    assign ctrl_io.RegWrite   = reg_write;
    assign ctrl_io.ALUSrcA    = alu_src_a;
    assign ctrl_io.ALUSrcB    = alu_src_b;
    assign ctrl_io.ResultSrc  = result_src;
    assign ctrl_io.ALUControl = alu_control;
    assign ctrl_io.Imm        = imm;
    assign ctrl_io.instr_done = instr_done;
    assign ctrl_io.illegal    = illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed cycle table on a trapping instance, then
// random instruction streams on a NOP-on-illegal instance against a phase-plan model.
module tb_multicycle_controller;

    localparam int unsigned XLEN = 64;

    typedef struct packed {
        logic       mem_req;
        logic       adr;
        logic       irw;
        logic       pcw;
        logic       mw;
        logic       rw;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] rsrc;
        logic [2:0] alu;
        logic       done;
        logic       ill;
    } outs_t;

    localparam outs_t O_FETCH_W = 17'b1_0_0_0_0_0_00_10_10_000_0_0;
    localparam outs_t O_FETCH_R = 17'b1_0_1_1_0_0_00_10_10_000_0_0;
    localparam outs_t O_DECODE  = 17'b0_0_0_0_0_0_01_01_00_000_0_0;
    localparam outs_t O_DEC_NOP = 17'b0_0_0_0_0_0_01_01_00_000_1_0;
    localparam outs_t O_MEMADR  = 17'b0_0_0_0_0_0_10_01_00_000_0_0;
    localparam outs_t O_MEMREAD = 17'b1_1_0_0_0_0_00_00_00_000_0_0;
    localparam outs_t O_MEMWB   = 17'b0_0_0_0_0_1_00_00_01_000_1_0;
    localparam outs_t O_MEMWR_W = 17'b1_1_0_0_1_0_00_00_00_000_0_0;
    localparam outs_t O_MEMWR_R = 17'b1_1_0_0_1_0_00_00_00_000_1_0;
    localparam outs_t O_EXECR   = 17'b0_0_0_0_0_0_10_00_00_000_0_0;
    localparam outs_t O_EXECI   = 17'b0_0_0_0_0_0_10_01_00_000_0_0;
    localparam outs_t O_ALUWB   = 17'b0_0_0_0_0_1_00_00_00_000_1_0;
    localparam outs_t O_BEQ_T   = 17'b0_0_0_1_0_0_10_00_00_001_1_0;
    localparam outs_t O_BEQ_F   = 17'b0_0_0_0_0_0_10_00_00_001_1_0;
    localparam outs_t O_JAL     = 17'b0_0_0_1_0_0_01_10_00_000_0_0;
    localparam outs_t O_TRAP    = 17'b0_0_0_0_0_0_00_00_00_000_0_1;

    localparam logic [31:0] I_LD  = 32'h36A3_3503;
    localparam logic [31:0] I_SD  = 32'h36A3_3523;
    localparam logic [31:0] I_BEQ = 32'h14A3_0563;
    localparam logic [31:0] I_ILL = 32'hFFFF_FFFF;

    typedef enum int {
        PhFetch, PhDecode, PhAddr, PhRead, PhLoadWb, PhWrite, PhExec, PhWb, PhBranch,
        PhJump, PhTrap
    } phase_e;

    typedef struct {
        logic        rst;
        logic [31:0] ins;
        logic        zero;
        logic        rdy;
        bit          chk;
        outs_t       exp;
        bit          chk_imm;
        logic [63:0] imm;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_trap, rst_nop;
    logic [31:0] ins_s;
    logic        zero_s, rdy_s;
    int          n_vec = 0;
    int          n_err = 0;
    vec_t        tbl[$];
    phase_e      plan[$];

    always #5 clk = ~clk;

    multicycle_controller_if #(.XLEN(XLEN)) bus_t ();
    multicycle_controller_if #(.XLEN(XLEN)) bus_n ();

    assign bus_t.Instruction = ins_s;
    assign bus_t.Zero        = zero_s;
    assign bus_t.mem_ready   = rdy_s;
    assign bus_n.Instruction = ins_s;
    assign bus_n.Zero        = zero_s;
    assign bus_n.mem_ready   = rdy_s;

    multicycle_controller #(.XLEN(XLEN), .TRAP_ON_ILLEGAL(1'b1)) dut_t (
        .clk     (clk),
        .rst     (rst_trap),
        .ctrl_io (bus_t)
    );

    multicycle_controller #(.XLEN(XLEN), .TRAP_ON_ILLEGAL(1'b0)) dut_n (
        .clk     (clk),
        .rst     (rst_nop),
        .ctrl_io (bus_n)
    );

    outs_t got_t, got_n;

    assign got_t = {bus_t.mem_req, bus_t.AdrSrc, bus_t.IRWrite, bus_t.PCWrite, bus_t.MemWrite,
                    bus_t.RegWrite, bus_t.ALUSrcA, bus_t.ALUSrcB, bus_t.ResultSrc,
                    bus_t.ALUControl, bus_t.instr_done, bus_t.illegal};
    assign got_n = {bus_n.mem_req, bus_n.AdrSrc, bus_n.IRWrite, bus_n.PCWrite, bus_n.MemWrite,
                    bus_n.RegWrite, bus_n.ALUSrcA, bus_n.ALUSrcB, bus_n.ResultSrc,
                    bus_n.ALUControl, bus_n.instr_done, bus_n.illegal};

    function automatic bit legal(input logic [31:0] ins);
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        bit alu_ok = f3 inside {3'b000, 3'b111, 3'b110, 3'b010};
        case (ins[6:0])
            7'b0000011, 7'b0100011: return f3 == 3'b010 || (f3 == 3'b011 && XLEN == 64);
            7'b0110011: return (f7 == 7'h00 && alu_ok) || (f7 == 7'h20 && f3 == 3'b000);
            7'b0010011: return alu_ok;
            7'b1100011, 7'b1101111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit has_imm(input logic [31:0] ins);
        return ins[6:0] inside {7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011, 7'b1101111};
    endfunction

    function automatic logic [63:0] imm_of(input logic [31:0] ins);
        logic signed [11:0] i12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        logic signed [63:0] r;
        r = '0;
        case (ins[6:0])
            7'b0000011, 7'b0010011: begin i12 = ins[31:20]; r = i12; end
            7'b0100011: begin i12 = {ins[31:25], ins[11:7]}; r = i12; end
            7'b1100011: begin b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; r = b13; end
            7'b1101111: begin
                j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                r = j21;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] alu_of(input logic [31:0] ins);
        case (ins[14:12])
            3'b000:  return (ins[6:0] == 7'b0110011 && ins[30]) ? 3'b001 : 3'b000;
            3'b111:  return 3'b010;
            3'b110:  return 3'b011;
            3'b010:  return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    // Expected outputs for one cycle spent in a given phase of an instruction.
    function automatic outs_t phase_out(input phase_e p, input logic [31:0] ins, input logic z,
                                        input logic rdy, input bit trap);
        outs_t o;
        case (p)
            PhFetch:  o = rdy ? O_FETCH_R : O_FETCH_W;
            PhDecode: o = (!legal(ins) && !trap) ? O_DEC_NOP : O_DECODE;
            PhAddr:   o = O_MEMADR;
            PhRead:   o = O_MEMREAD;
            PhLoadWb: o = O_MEMWB;
            PhWrite:  o = rdy ? O_MEMWR_R : O_MEMWR_W;
            PhExec: begin
                o = (ins[6:0] == 7'b0010011) ? O_EXECI : O_EXECR;
                o.alu = alu_of(ins);
            end
            PhWb:     o = O_ALUWB;
            PhBranch: o = z ? O_BEQ_T : O_BEQ_F;
            PhJump:   o = O_JAL;
            default:  o = O_TRAP;
        endcase
        return o;
    endfunction

    task automatic build_plan(input logic [31:0] ins, input bit trap);
        plan = '{PhFetch, PhDecode};
        if (!legal(ins)) begin
            if (trap) plan.push_back(PhTrap);
        end else begin
            case (ins[6:0])
                7'b0000011: begin plan.push_back(PhAddr); plan.push_back(PhRead);
                                  plan.push_back(PhLoadWb); end
                7'b0100011: begin plan.push_back(PhAddr); plan.push_back(PhWrite); end
                7'b1100011: plan.push_back(PhBranch);
                7'b1101111: begin plan.push_back(PhJump); plan.push_back(PhWb); end
                default:    begin plan.push_back(PhExec); plan.push_back(PhWb); end
            endcase
        end
    endtask

    function automatic logic [31:0] gen_ins();
        logic [31:0] r = $urandom;
        logic [2:0]  alu_f3[4] = '{3'b000, 3'b111, 3'b110, 3'b010};
        int unsigned k = $urandom_range(0, 7);
        case (k)
            0, 1: begin
                r[6:0] = (k == 0) ? 7'b0000011 : 7'b0100011;
                if ($urandom_range(0, 1) == 1) r[14:12] = 3'($urandom_range(2, 3));
            end
            2, 3: begin
                r[6:0] = (k == 2) ? 7'b0110011 : 7'b0010011;
                if ($urandom_range(0, 1) == 1) r[14:12] = alu_f3[$urandom_range(0, 3)];
                if (k == 2 && $urandom_range(0, 3) != 0)
                    r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
            4: r[6:0] = 7'b1100011;
            5: r[6:0] = 7'b1101111;
            6: r[6:0] = 7'($urandom);
            default: ;
        endcase
        return r;
    endfunction

    task automatic chk_o(input string nm, input outs_t got, input outs_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: outputs got %b required %b", nm, got, exp);
        end
    endtask

    task automatic chk_imm(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s imm: got %0d required %0d", nm, $signed(got), $signed(exp));
        end
    endtask

    task automatic drive(input logic rt, input logic rn, input logic [31:0] ins, input logic z,
                         input logic rdy);
        @(negedge clk);
        rst_trap = rt;
        rst_nop  = rn;
        ins_s    = ins;
        zero_s   = z;
        rdy_s    = rdy;
        #2;
    endtask

    task automatic add(input logic r, input logic [31:0] ins, input logic z, input logic rdy,
                       input bit c, input outs_t e, input bit ci = 1'b0,
                       input logic [63:0] im = '0);
        vec_t v;
        v.rst = r; v.ins = ins; v.zero = z; v.rdy = rdy;
        v.chk = c; v.exp = e; v.chk_imm = ci; v.imm = im;
        tbl.push_back(v);
    endtask

    task automatic build_table();
        logic [31:0] rins[4] = '{32'h00A3_0533, 32'h40A3_0533, 32'h00A3_7533, 32'h00A3_6533};
        logic [2:0]  ralu[4] = '{3'b000, 3'b001, 3'b010, 3'b011};
        outs_t       ex;
        add(1, I_LD, 0, 0, 0, O_TRAP);
        add(0, I_LD, 0, 0, 1, O_FETCH_W);
        add(0, I_LD, 0, 1, 1, O_FETCH_R);
        add(0, I_LD, 0, 1, 1, O_DECODE);
        add(0, I_LD, 0, 1, 1, O_MEMADR, 1, 64'd874);
        add(0, I_LD, 0, 1, 1, O_MEMREAD);
        add(0, I_LD, 0, 1, 1, O_MEMWB);
        add(0, I_SD, 0, 1, 1, O_FETCH_R);
        add(0, I_SD, 0, 1, 1, O_DECODE);
        add(0, I_SD, 0, 1, 1, O_MEMADR, 1, 64'd874);
        for (int k = 0; k < 3; k++) add(0, I_SD, 0, 0, 1, O_MEMWR_W);
        add(0, I_SD, 0, 1, 1, O_MEMWR_R);
        for (int k = 0; k < 4; k++) begin
            ex = O_EXECR;
            ex.alu = ralu[k];
            add(0, rins[k], 0, 1, 1, O_FETCH_R);
            add(0, rins[k], 0, 1, 1, O_DECODE);
            add(0, rins[k], 0, 1, 1, ex);
            add(0, rins[k], 0, 1, 1, O_ALUWB);
        end
        add(0, I_BEQ, 0, 1, 1, O_FETCH_R);
        add(0, I_BEQ, 0, 1, 1, O_DECODE, 1, 64'd330);
        add(0, I_BEQ, 1, 1, 1, O_BEQ_T);
        add(0, I_BEQ, 0, 1, 1, O_FETCH_R);
        add(0, I_BEQ, 0, 1, 1, O_DECODE);
        add(0, I_BEQ, 0, 1, 1, O_BEQ_F);
        // Reset landing in a stalled load read must abandon it before writeback.
        add(0, I_LD, 0, 1, 1, O_FETCH_R);
        add(0, I_LD, 0, 1, 1, O_DECODE);
        add(0, I_LD, 0, 1, 1, O_MEMADR);
        add(0, I_LD, 0, 0, 1, O_MEMREAD);
        add(1, I_LD, 0, 0, 1, O_MEMREAD);
        add(0, I_LD, 0, 0, 1, O_FETCH_W);
        add(0, I_LD, 0, 0, 1, O_FETCH_W);
        add(0, I_ILL, 0, 1, 1, O_FETCH_R);
        add(0, I_ILL, 0, 1, 1, O_DECODE);
        add(0, I_ILL, 0, 1, 1, O_TRAP);
        add(0, I_ILL, 0, 0, 1, O_TRAP);
        add(0, I_ILL, 1, 1, 1, O_TRAP);
    endtask

    initial begin
        logic [31:0] ins;
        logic        z, rdy;
        int          waits;
        bit          stay;

        rst_trap = 1'b1;
        rst_nop  = 1'b1;
        ins_s    = '0;
        zero_s   = 1'b0;
        rdy_s    = 1'b0;
        build_table();

        foreach (tbl[i]) begin
            drive(tbl[i].rst, 1'b1, tbl[i].ins, tbl[i].zero, tbl[i].rdy);
            if (tbl[i].chk) chk_o($sformatf("table row %0d", i), got_t, tbl[i].exp);
            if (tbl[i].chk_imm) chk_imm($sformatf("table row %0d", i), bus_t.Imm, tbl[i].imm);
        end

        // Trap must hold against any input activity until reset.
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 1'b1, $urandom, 1'($urandom), 1'($urandom));
            chk_o($sformatf("trap sticky %0d", c), got_t, O_TRAP);
        end
        drive(1'b1, 1'b1, I_ILL, 1'b0, 1'b0);
        chk_o("trap under rst", got_t, O_TRAP);
        drive(1'b0, 1'b1, I_ILL, 1'b0, 1'b0);
        chk_o("trap cleared by rst", got_t, O_FETCH_W);

        drive(1'b1, 1'b0, I_ILL, 1'b0, 1'b0);
        chk_o("nop reset state", got_n, O_FETCH_W);
        drive(1'b1, 1'b0, I_ILL, 1'b0, 1'b1);
        chk_o("nop fetch", got_n, O_FETCH_R);
        drive(1'b1, 1'b0, I_ILL, 1'b0, 1'b1);
        chk_o("nop decode retire", got_n, O_DEC_NOP);
        drive(1'b1, 1'b0, I_ILL, 1'b0, 1'b0);
        chk_o("nop back to fetch", got_n, O_FETCH_W);
        drive(1'b1, 1'b0, I_ILL, 1'b0, 1'b0);
        chk_o("nop fetch hold", got_n, O_FETCH_W);

        for (int n = 0; n < 300; n++) begin
            ins = gen_ins();
            build_plan(ins, 1'b0);
            foreach (plan[p]) begin
                waits = 0;
                do begin
                    z   = 1'($urandom);
                    rdy = (waits >= 6) ? 1'b1 : 1'($urandom);
                    drive(1'b1, 1'b0, ins, z, rdy);
                    chk_o($sformatf("rand %0d ins %h phase %0d", n, ins, p), got_n,
                          phase_out(plan[p], ins, z, rdy, 1'b0));
                    if (has_imm(ins)) chk_imm($sformatf("rand %0d ins %h", n, ins), bus_n.Imm,
                                              imm_of(ins));
                    stay = (plan[p] inside {PhFetch, PhRead, PhWrite}) && !rdy;
                    waits++;
                end while (stay);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
